// File: rtl/iiomem_clint.sv
// CLINT-style timer and software-interrupt unit behind an AXI-lite responder for the iiomem window.
// Optional feature: define CLINT_MTIME_WRITE_EN to make MTIME_LO/MTIME_HI writable.
module iiomem_clint #(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          STRB_W   = DATA_W / 8,
  parameter logic [31:0] ID_VALUE = 32'h434C_4E54
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic [2:0]        s_axil_awprot,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [DATA_W-1:0] s_axil_wdata,
  input  logic [STRB_W-1:0] s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic [2:0]        s_axil_arprot,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [DATA_W-1:0] s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic              timer_irq,
  output logic              sw_irq
);

  localparam logic [9:0] OFF_MSIP     = 10'h000;
  localparam logic [9:0] OFF_CMP_LO   = 10'h002;
  localparam logic [9:0] OFF_CMP_HI   = 10'h003;
  localparam logic [9:0] OFF_MTIME_LO = 10'h004;
  localparam logic [9:0] OFF_MTIME_HI = 10'h005;
  localparam logic [9:0] OFF_PRESCALE = 10'h006;
  localparam logic [9:0] OFF_ID       = 10'h007;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic [15:0] prescale;
  logic [15:0] pcnt;
  logic [31:0] mtime_hi_shadow;

  logic        aw_held;
  logic [9:0]  aw_off;
  logic        w_held;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  logic        wr_en;
  logic        wr_err;
  logic        wr_ok;
  logic        rd_hs;
  logic [9:0]  ar_off;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        tick;

  // Protection bits and address bits outside the decoded window are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       s_axil_awaddr[ADDR_W-1:12], s_axil_awaddr[1:0],
                       s_axil_araddr[ADDR_W-1:12], s_axil_araddr[1:0]};

  assign s_axil_awready = !aw_held && !bvalid_q;
  assign s_axil_wready  = !w_held && !bvalid_q;
  assign s_axil_arready = !rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;

  assign wr_en  = aw_held && w_held && !bvalid_q;
  assign wr_ok  = wr_en && !wr_err;
  assign rd_hs  = s_axil_arvalid && !rvalid_q;
  assign ar_off = s_axil_araddr[11:2];
  assign tick   = (pcnt == prescale);

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_err = 1'b1;
    case (aw_off)
      OFF_MSIP, OFF_CMP_LO, OFF_CMP_HI, OFF_PRESCALE: wr_err = 1'b0;
`ifdef CLINT_MTIME_WRITE_EN
      OFF_MTIME_LO, OFF_MTIME_HI:                     wr_err = 1'b0;
`endif
      default:                                        wr_err = 1'b1;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (ar_off)
      OFF_MSIP:     rd_data = {31'h0, msip};
      OFF_CMP_LO:   rd_data = mtimecmp[31:0];
      OFF_CMP_HI:   rd_data = mtimecmp[63:32];
      OFF_MTIME_LO: rd_data = mtime[31:0];
      OFF_MTIME_HI: rd_data = mtime_hi_shadow;
      OFF_PRESCALE: rd_data = {16'h0, prescale};
      OFF_ID:       rd_data = ID_VALUE;
      default:      rd_err  = 1'b1;
    endcase
  end

  // Write channel: AW and W park independently, commit once both are present, B holds until bready.
  // NOTE: clocked state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      aw_held  <= 1'b0;
      aw_off   <= '0;
      w_held   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      msip     <= 1'b0;
      mtimecmp <= '1;
      prescale <= '0;
    end else begin
      if (s_axil_awvalid && s_axil_awready) begin
        aw_held <= 1'b1;
        aw_off  <= s_axil_awaddr[11:2];
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      if (wr_en) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s_axil_bready) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
      if (wr_ok) begin
        case (aw_off)
          OFF_MSIP:     if (w_strb[0]) msip <= w_data[0];
          OFF_CMP_LO:   mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], w_data, w_strb);
          OFF_CMP_HI:   mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], w_data, w_strb);
          OFF_PRESCALE: begin
            if (w_strb[0]) prescale[7:0]  <= w_data[7:0];
            if (w_strb[1]) prescale[15:8] <= w_data[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  // Timebase: a PRESCALE write restarts the divider; an mtime write suppresses that cycle's tick.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      pcnt  <= '0;
      mtime <= '0;
    end else begin
      if (wr_ok && aw_off == OFF_PRESCALE) pcnt <= '0;
      else                                 pcnt <= tick ? 16'h0 : pcnt + 16'h1;
`ifdef CLINT_MTIME_WRITE_EN
      if (wr_ok && aw_off == OFF_MTIME_LO)
        mtime[31:0] <= merge_bytes(mtime[31:0], w_data, w_strb);
      else if (wr_ok && aw_off == OFF_MTIME_HI)
        mtime[63:32] <= merge_bytes(mtime[63:32], w_data, w_strb);
      else if (tick)
        mtime <= mtime + 64'h1;
`else
      if (tick) mtime <= mtime + 64'h1;
`endif
    end
  end

  // Read channel: one-cycle latency; an MTIME_LO read snapshots the upper half for a coherent HI read.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rvalid_q        <= 1'b0;
      rresp_q         <= RESP_OKAY;
      rdata_q         <= '0;
      mtime_hi_shadow <= '0;
    end else begin
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        if (ar_off == OFF_MTIME_LO) mtime_hi_shadow <= mtime[63:32];
      end else if (rvalid_q && s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      timer_irq <= 1'b0;
      sw_irq    <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
      sw_irq    <= msip;
    end
  end

endmodule

// File: tb/tb_iiomem_clint.sv
// Directed self-checking bench for iiomem_clint; honours CLINT_MTIME_WRITE_EN when defined.
module tb_iiomem_clint;

  localparam logic [31:0] A_MSIP     = 32'h0000_0000;
  localparam logic [31:0] A_CMP_LO   = 32'h0000_0008;
  localparam logic [31:0] A_CMP_HI   = 32'h0000_000C;
  localparam logic [31:0] A_MTIME_LO = 32'h0000_0010;
  localparam logic [31:0] A_MTIME_HI = 32'h0000_0014;
  localparam logic [31:0] A_PRESCALE = 32'h0000_0018;
  localparam logic [31:0] A_ID       = 32'h0000_001C;

  logic        clk = 1'b0;
  logic        core_rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        timer_irq;
  logic        sw_irq;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] m_mtime;

  always #5 clk = ~clk;

  // Reference count of mtime, valid while PRESCALE is 0 after a reset.
  always @(posedge clk) m_mtime <= core_rst ? 64'h0 : m_mtime + 64'h1;

  iiomem_clint dut (
    .core_clk       (clk),
    .core_rst       (core_rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .timer_irq      (timer_irq),
    .sw_irq         (sw_irq)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int   n;
    logic aw_hs;
    logic w_hs;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bvalid_seen", 64'(bvalid), 64'h1);
    resp = bresp;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output logic lat1);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    lat1 = rvalid;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rvalid_seen", 64'(rvalid), 64'h1);
    data = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] d2;
    logic [1:0]  r;
    logic        lat;
    logic        hold_ok;
    int          n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(awready), 64'h1);
    check("rst_wready",  64'(wready),  64'h1);
    check("rst_arready", 64'(arready), 64'h1);
    check("rst_bvalid",  64'(bvalid),  64'h0);
    check("rst_rvalid",  64'(rvalid),  64'h0);
    check("rst_bresp",   64'(bresp),   64'h0);
    check("rst_rresp",   64'(rresp),   64'h0);
    check("rst_rdata",   64'(rdata),   64'h0);
    check("rst_timer_irq", 64'(timer_irq), 64'h0);
    check("rst_sw_irq",  64'(sw_irq),  64'h0);
    core_rst = 1'b0;

    // Free-running mtime with PRESCALE=0, coherent LO/HI read
    repeat (100) @(negedge clk);
    axi_read(A_MTIME_LO, d, r, lat);
    check("mtime_lo_in_range", 64'((d >= 32'd100) && (d <= 32'd103)), 64'h1);
    check("mtime_lo_rresp", 64'(r), 64'h0);
    check("rvalid_latency_1", 64'(lat), 64'h1);
    axi_read(A_MTIME_HI, d, r, lat);
    check("mtime_hi_zero", 64'(d), 64'h0);
    check("mtime_hi_rresp", 64'(r), 64'h0);

    // Timer compare around mtime == mtimecmp
    @(negedge clk); core_rst = 1'b1;
    @(negedge clk); core_rst = 1'b0;
    axi_write(A_CMP_HI, 32'h0, 4'hF, r);
    check("cmp_hi_bresp", 64'(r), 64'h0);
    axi_write(A_CMP_LO, 32'd50, 4'hF, r);
    check("cmp_lo_bresp", 64'(r), 64'h0);
    check("irq_low_early", 64'(timer_irq), 64'h0);
    n = 0;
    while (m_mtime < 64'd49 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("irq_at_mtime49", 64'(timer_irq), 64'h0);
    @(negedge clk);
    check("irq_at_mtime50", 64'(timer_irq), 64'h0);
    @(negedge clk);
    check("irq_after_mtime50", 64'(timer_irq), 64'h1);
    axi_write(A_CMP_LO, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(A_CMP_HI, 32'hFFFF_FFFF, 4'hF, r);
    check("irq_cleared_cmp_max", 64'(timer_irq), 64'h0);

    // MSIP write with W ahead of AW and a stalled B channel
    @(negedge clk);
    check("w_first_ready", 64'(wready), 64'h1);
    wdata = 32'h1; wstrb = 4'b0001; wvalid = 1'b1; bready = 1'b0; awvalid = 1'b0;
    @(negedge clk); wvalid = 1'b0;
    check("wready_while_w_held", 64'(wready), 64'h0);
    @(negedge clk);
    @(negedge clk);
    awaddr = A_MSIP; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    hold_ok = 1'b1;
    repeat (5) begin
      if (!(bvalid && !awready && !wready)) hold_ok = 1'b0;
      @(negedge clk);
    end
    check("b_stall_hold", 64'(hold_ok), 64'h1);
    check("msip_bresp", 64'(bresp), 64'h0);
    check("sw_irq_set", 64'(sw_irq), 64'h1);
    bready = 1'b1;
    @(negedge clk); bready = 1'b0;
    check("b_done_bvalid", 64'(bvalid), 64'h0);
    check("b_done_ready", 64'({awready, wready}), 64'h3);
    axi_read(A_MSIP, d, r, lat);
    check("msip_read", 64'(d), 64'h1);

    // Error responses, ID, byte strobes, address aliasing
    axi_read(32'h0000_0040, d, r, lat);
    check("bad_rd_rresp", 64'(r), 64'h2);
    check("bad_rd_rdata", 64'(d), 64'h0);
    axi_write(A_ID, 32'h1234_5678, 4'hF, r);
    check("id_wr_bresp", 64'(r), 64'h2);
    axi_read(A_ID, d, r, lat);
    check("id_value", 64'(d), 64'h434C_4E54);
    check("id_rresp", 64'(r), 64'h0);
    axi_read(32'h0001_F01F, d, r, lat);
    check("id_alias", 64'(d), 64'h434C_4E54);
    axi_write(A_CMP_LO, 32'h00AA_0000, 4'b0100, r);
    axi_read(A_CMP_LO, d, r, lat);
    check("cmp_lo_byte_lane", 64'(d), 64'hFFAA_FFFF);
    axi_write(A_PRESCALE, 32'hABCD_1234, 4'b0011, r);
    axi_read(A_PRESCALE, d, r, lat);
    check("prescale_read", 64'(d), 64'h0000_1234);

    // MTIME write path
`ifdef CLINT_MTIME_WRITE_EN
    axi_write(A_MTIME_LO, 32'hFFFF_FFF0, 4'hF, r);
    check("mtime_lo_wr_bresp", 64'(r), 64'h0);
    axi_write(A_MTIME_HI, 32'h0, 4'hF, r);
    check("mtime_hi_wr_bresp", 64'(r), 64'h0);
    axi_write(A_PRESCALE, 32'h0, 4'hF, r);
    repeat (20) @(negedge clk);
    axi_read(A_MTIME_LO, d, r, lat);
    check("mtime_lo_wrapped", 64'(d < 32'h40), 64'h1);
    axi_read(A_MTIME_HI, d, r, lat);
    check("mtime_hi_carry", 64'(d), 64'h1);
`else
    axi_write(A_MTIME_LO, 32'hFFFF_FFF0, 4'hF, r);
    check("mtime_lo_wr_slverr", 64'(r), 64'h2);
    axi_write(A_MTIME_HI, 32'h0, 4'hF, r);
    check("mtime_hi_wr_slverr", 64'(r), 64'h2);
    axi_write(A_PRESCALE, 32'h0, 4'hF, r);
    axi_read(A_MTIME_LO, d, r, lat);
    repeat (20) @(negedge clk);
    axi_read(A_MTIME_LO, d2, r, lat);
    check("mtime_keeps_counting", 64'((d2 - d) >= 32'd20 && (d2 - d) <= 32'd30), 64'h1);
    axi_read(A_MTIME_HI, d, r, lat);
    check("mtime_hi_untouched", 64'(d), 64'h0);
`endif

    // Reset while R is pending and AW is parked
    @(negedge clk);
    araddr = A_ID; arvalid = 1'b1; rready = 1'b0;
    awaddr = A_CMP_LO; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    check("pre_rst_rvalid", 64'(rvalid), 64'h1);
    check("pre_rst_aw_held", 64'(awready), 64'h0);
    core_rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rvalid", 64'(rvalid), 64'h0);
    check("mid_rst_bvalid", 64'(bvalid), 64'h0);
    check("mid_rst_readies", 64'({awready, wready, arready}), 64'h7);
    check("mid_rst_irqs", 64'({timer_irq, sw_irq}), 64'h0);
    core_rst = 1'b0;
    axi_read(A_MTIME_LO, d, r, lat);
    check("mtime_restart", 64'(d), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
